// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NUM_REQ requesters.
// Also carries the isa_shared operation encoding, so the design file stands alone.
package isa_shared;
  typedef enum logic [3:0] {
    ALU_NOP = 4'd0,
    ALU_ADD = 4'd1,
    ALU_SUB = 4'd2,
    ALU_AND = 4'd3,
    ALU_OR  = 4'd4,
    ALU_XOR = 4'd5,
    ALU_SLT = 4'd6,
    ALU_SLL = 4'd7,
    ALU_SRL = 4'd8,
    ALU_SRA = 4'd9
  } alu_ops_e;
endpackage

module alu_arbiter
  import isa_shared::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 2,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  input  alu_ops_e [NUM_REQ-1:0]        req_op,
  output logic [DATA_WIDTH-1:0]         alu_a,
  output logic [DATA_WIDTH-1:0]         alu_b,
  output alu_ops_e                      alu_op,
  input  logic [DATA_WIDTH-1:0]         alu_result,
  input  logic                          alu_zero,
  input  logic                          alu_carry,
  input  logic                          alu_overflow,
  output logic                          resp_valid,
  output logic [ID_W-1:0]               resp_id,
  output logic [DATA_WIDTH-1:0]         resp_result,
  output logic                          resp_zero,
  output logic                          resp_carry,
  output logic                          resp_overflow
);

  logic [ID_W-1:0]       r_ptr;
  logic                  r_vld_p1;
  logic [ID_W-1:0]       r_id_p1;
  logic [DATA_WIDTH-1:0] r_result_p1;
  logic                  r_zero_p1;
  logic                  r_carry_p1;
  logic                  r_overflow_p1;

  logic                  w_win_vld;
  logic [ID_W-1:0]       w_win_idx;
  logic [ID_W-1:0]       w_cand;
  logic [ID_W-1:0]       w_ptr_nxt;
  int                    w_sum;

  // Stage p0: round-robin search starting at r_ptr; r_ptr never holds a code >= NUM_REQ.
  always_comb begin
    w_win_vld = 1'b0;
    w_win_idx = '0;
    w_cand    = '0;
    w_sum     = 0;
    if (en && rst_n) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        w_sum = int'(r_ptr) + k;
        if (w_sum >= NUM_REQ) w_sum = w_sum - NUM_REQ;
        w_cand = ID_W'(w_sum);
        if (!w_win_vld && req_valid[w_cand]) begin
          w_win_vld = 1'b1;
          w_win_idx = w_cand;
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    alu_a     = '0;
    alu_b     = '0;
    alu_op    = ALU_NOP;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_win_vld && (w_win_idx == ID_W'(k))) begin
        req_ready[k] = 1'b1;
        alu_a        = req_a[k*DATA_WIDTH +: DATA_WIDTH];
        alu_b        = req_b[k*DATA_WIDTH +: DATA_WIDTH];
        alu_op       = req_op[k];
      end
    end
  end

  always_comb begin
    if (w_win_idx == ID_W'(NUM_REQ - 1)) w_ptr_nxt = '0;
    else                                 w_ptr_nxt = w_win_idx + ID_W'(1);
  end

  // Stage p1: capture the ALU outcome of the accepted request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr         <= '0;
      r_vld_p1      <= 1'b0;
      r_id_p1       <= '0;
      r_result_p1   <= '0;
      r_zero_p1     <= 1'b0;
      r_carry_p1    <= 1'b0;
      r_overflow_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= w_win_vld;
      if (w_win_vld) begin
        r_ptr         <= w_ptr_nxt;
        r_id_p1       <= w_win_idx;
        r_result_p1   <= alu_result;
        r_zero_p1     <= alu_zero;
        r_carry_p1    <= alu_carry;
        r_overflow_p1 <= alu_overflow;
      end
    end
  end

  assign resp_valid    = r_vld_p1;
  assign resp_id       = r_id_p1;
  assign resp_result   = r_result_p1;
  assign resp_zero     = r_zero_p1;
  assign resp_carry    = r_carry_p1;
  assign resp_overflow = r_overflow_p1;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter with three requesters, a behavioural ALU stub and a
// round-robin reference model updated once per clock.
module tb_alu_arbiter;
  import isa_shared::*;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int IW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*DW-1:0] req_a;
  logic [N*DW-1:0] req_b;
  alu_ops_e [N-1:0] req_op;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  alu_ops_e      alu_op;
  logic [DW-1:0] alu_result;
  logic          alu_zero;
  logic          alu_carry;
  logic          alu_overflow;
  logic          resp_valid;
  logic [IW-1:0] resp_id;
  logic [DW-1:0] resp_result;
  logic          resp_zero;
  logic          resp_carry;
  logic          resp_overflow;

  logic [DW-1:0] ta [N];
  logic [DW-1:0] tb [N];
  alu_ops_e      to [N];

  int total = 0;
  int bad   = 0;

  int            m_ptr;
  logic          m_rv;
  int            m_rid;
  logic [DW-1:0] m_res;
  logic          m_z, m_c, m_o;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_a[g*DW +: DW] = ta[g];
    assign req_b[g*DW +: DW] = tb[g];
    assign req_op[g]         = to[g];
  end

  alu_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_result(resp_result),
    .resp_zero(resp_zero), .resp_carry(resp_carry), .resp_overflow(resp_overflow)
  );

  // Returns {overflow, carry, zero, result}.
  function automatic logic [DW+2:0] ref_alu(logic [DW-1:0] a, logic [DW-1:0] b, alu_ops_e op);
    logic [DW:0]   wide;
    logic [DW-1:0] r;
    logic          c, o;
    wide = '0; c = 1'b0; o = 1'b0;
    case (op)
      ALU_ADD: begin wide = {1'b0, a} + {1'b0, b}; r = wide[DW-1:0]; c = wide[DW];
                     o = (a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]); end
      ALU_SUB: begin wide = {1'b0, a} - {1'b0, b}; r = wide[DW-1:0]; c = wide[DW];
                     o = (a[DW-1] != b[DW-1]) && (r[DW-1] != a[DW-1]); end
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      default: r = '0;
    endcase
    return {o, c, (r == '0), r};
  endfunction

  always_comb {alu_overflow, alu_carry, alu_zero, alu_result} = ref_alu(alu_a, alu_b, alu_op);

  function automatic int m_winner();
    int idx;
    if (!(en && rst_n)) return -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (req_valid[IW'(idx)]) return idx;
    end
    return -1;
  endfunction

  // Advances the reference model with the inputs present before the edge, then steps one clock.
  task automatic tick();
    int w;
    w = m_winner();
    if (!rst_n) begin
      m_ptr = 0; m_rv = 1'b0; m_rid = 0; m_res = '0; m_z = 1'b0; m_c = 1'b0; m_o = 1'b0;
    end else if (w >= 0) begin
      {m_o, m_c, m_z, m_res} = ref_alu(ta[w], tb[w], to[w]);
      m_rv  = 1'b1;
      m_rid = w;
      m_ptr = (w + 1) % N;
    end else begin
      m_rv = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    for (int k = 0; k < N; k++) begin
      ta[k] = '0; tb[k] = '0; to[k] = ALU_NOP;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    en = 1'b1;
    rst_n = 1'b0;
    req_valid = '1;
    for (int k = 0; k < N; k++) begin
      ta[k] = $urandom() | 32'h1; tb[k] = $urandom(); to[k] = ALU_ADD;
    end
    for (int c = 0; c < 2; c++) begin
      #1;
      total++; if (req_ready !== '0) begin bad++; $display("FAIL reset_ready cyc%0d: got %b want 000", c, req_ready); end
      total++; if (alu_op !== ALU_NOP) begin bad++; $display("FAIL reset_alu_op cyc%0d: got %0d want %0d", c, alu_op, ALU_NOP); end
      total++; if (alu_a !== '0) begin bad++; $display("FAIL reset_alu_a cyc%0d: got %h want 0", c, alu_a); end
      tick();
      total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid cyc%0d: got %b want 0", c, resp_valid); end
      total++; if (resp_result !== '0 || resp_id !== '0) begin bad++; $display("FAIL reset_resp_regs cyc%0d: got id=%0d res=%h want 0/0", c, resp_id, resp_result); end
    end
    rst_n = 1'b1;
    #1;
    total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL reset_first_grant: got %b want 001", req_ready); end
    tick();
    total++; if (resp_valid !== 1'b1 || resp_id !== 2'd0) begin bad++; $display("FAIL reset_first_resp: got v=%b id=%0d want 1/0", resp_valid, resp_id); end
    clear_reqs();
  endtask

  task automatic test_single();
    do_reset();
    clear_reqs();
    req_valid = 3'b010;
    ta[1] = 32'h7FFF_FFFF; tb[1] = 32'h0000_0001; to[1] = ALU_ADD;
    #1;
    total++; if (req_ready !== 3'b010) begin bad++; $display("FAIL single_ready: got %b want 010", req_ready); end
    tick();
    clear_reqs();
    total++; if (resp_valid !== 1'b1 || resp_id !== 2'd1) begin bad++; $display("FAIL single_resp: got v=%b id=%0d want 1/1", resp_valid, resp_id); end
    total++; if (resp_result !== 32'h8000_0000) begin bad++; $display("FAIL single_result: got %h want 80000000", resp_result); end
    total++; if (resp_overflow !== 1'b1 || resp_carry !== 1'b0) begin bad++; $display("FAIL single_flags: got ov=%b c=%b want 1/0", resp_overflow, resp_carry); end
    tick();
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL single_drop: got %b want 0", resp_valid); end
    total++; if (resp_result !== 32'h8000_0000) begin bad++; $display("FAIL single_hold: got %h want 80000000", resp_result); end
  endtask

  task automatic test_contention();
    do_reset();
    clear_reqs();
    req_valid = 3'b011;
    for (int i = 0; i < 6; i++) begin
      ta[0] = $urandom(); tb[0] = $urandom(); to[0] = ALU_XOR;
      ta[1] = $urandom(); tb[1] = $urandom(); to[1] = ALU_SUB;
      #1;
      total++; if (req_ready !== ((i % 2 == 0) ? 3'b001 : 3'b010)) begin bad++; $display("FAIL contend_ready cyc%0d: got %b want grant %0d", i, req_ready, i % 2); end
      tick();
      total++; if (resp_valid !== 1'b1 || resp_id !== IW'(i % 2)) begin bad++; $display("FAIL contend_resp cyc%0d: got v=%b id=%0d want 1/%0d", i, resp_valid, resp_id, i % 2); end
      total++; if (resp_result !== m_res) begin bad++; $display("FAIL contend_result cyc%0d: got %h want %h", i, resp_result, m_res); end
    end
    clear_reqs();
  endtask

  task automatic test_stall();
    do_reset();
    clear_reqs();
    req_valid = 3'b011;
    to[0] = ALU_OR; ta[0] = 32'h00F0_0000; tb[0] = 32'h0000_000F;
    to[1] = ALU_ADD; ta[1] = 32'h1; tb[1] = 32'h2;
    #1;
    total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL stall_pre_grant: got %b want 001", req_ready); end
    tick();
    en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 0) begin
        total++; if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_result !== 32'h00F0_000F) begin
          bad++; $display("FAIL stall_inflight: got v=%b id=%0d res=%h want 1/0/00f0000f", resp_valid, resp_id, resp_result); end
      end
      #1;
      total++; if (req_ready !== '0 || alu_op !== ALU_NOP) begin bad++; $display("FAIL stall_block cyc%0d: got ready=%b op=%0d want 000/0", c, req_ready, alu_op); end
      tick();
      total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL stall_resp cyc%0d: got %b want 0", c, resp_valid); end
    end
    en = 1'b1;
    #1;
    total++; if (req_ready !== 3'b010) begin bad++; $display("FAIL stall_resume: got %b want 010", req_ready); end
    clear_reqs();
  endtask

  task automatic test_idle();
    clear_reqs();
    ta[2] = 32'hDEAD_BEEF; tb[2] = 32'h1234_5678; to[2] = ALU_ADD;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (alu_op !== ALU_NOP || alu_a !== '0 || alu_b !== '0 || req_ready !== '0) begin
        bad++; $display("FAIL idle_drive cyc%0d: got op=%0d a=%h b=%h rdy=%b want 0/0/0/000", c, alu_op, alu_a, alu_b, req_ready); end
      tick();
      total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL idle_resp cyc%0d: got %b want 0", c, resp_valid); end
    end
    req_valid = 3'b111;
    #1;
    total++; if (req_ready !== 3'b010) begin bad++; $display("FAIL idle_ptr_hold: got %b want 010", req_ready); end
    clear_reqs();
  endtask

  task automatic test_wrap();
    clear_reqs();
    req_valid = 3'b100;
    ta[2] = 32'h5; tb[2] = 32'h3; to[2] = ALU_SUB;
    #1;
    total++; if (req_ready !== 3'b100) begin bad++; $display("FAIL wrap_req2: got %b want 100", req_ready); end
    tick();
    req_valid = 3'b111;
    ta[0] = 32'hFFFF_FFFF; tb[0] = 32'h1; to[0] = ALU_ADD;
    #1;
    total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL wrap_grant: got %b want 001", req_ready); end
    tick();
    total++; if (resp_id !== 2'd0 || resp_result !== '0 || resp_zero !== 1'b1 || resp_carry !== 1'b1) begin
      bad++; $display("FAIL wrap_resp: got id=%0d res=%h z=%b c=%b want 0/0/1/1", resp_id, resp_result, resp_zero, resp_carry); end
    clear_reqs();
  endtask

  task automatic test_fairness();
    int cnt [N];
    do_reset();
    for (int k = 0; k < N; k++) cnt[k] = 0;
    req_valid = '1;
    for (int c = 0; c < 3 * N; c++) begin
      #1;
      for (int k = 0; k < N; k++) if (req_ready[k]) cnt[k]++;
      tick();
    end
    for (int k = 0; k < N; k++) begin
      total++; if (cnt[k] != 3) begin bad++; $display("FAIL fair_count req%0d: got %0d want 3", k, cnt[k]); end
    end
    clear_reqs();
  endtask

  task automatic test_random();
    int w;
    logic [N-1:0] exp_rdy;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst_n = ($urandom_range(0, 19) != 0);
      en    = ($urandom_range(0, 9) != 0);
      req_valid = N'($urandom());
      for (int k = 0; k < N; k++) begin
        ta[k] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom();
        tb[k] = ($urandom_range(0, 3) == 0) ? 32'h1 : $urandom();
        to[k] = alu_ops_e'(4'($urandom_range(0, 5)));
      end
      #1;
      w = m_winner();
      exp_rdy = (w >= 0) ? N'(1 << w) : '0;
      total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL rnd_ready cyc%0d: got %b want %b", c, req_ready, exp_rdy); end
      total++; if (alu_a !== ((w >= 0) ? ta[w] : '0) || alu_b !== ((w >= 0) ? tb[w] : '0) || alu_op !== ((w >= 0) ? to[w] : ALU_NOP)) begin
        bad++; $display("FAIL rnd_alu_drive cyc%0d: got a=%h b=%h op=%0d winner=%0d", c, alu_a, alu_b, alu_op, w); end
      tick();
      total++; if (resp_valid !== m_rv || resp_id !== IW'(m_rid)) begin
        bad++; $display("FAIL rnd_resp cyc%0d: got v=%b id=%0d want %b/%0d", c, resp_valid, resp_id, m_rv, m_rid); end
      total++; if (resp_result !== m_res || resp_zero !== m_z || resp_carry !== m_c || resp_overflow !== m_o) begin
        bad++; $display("FAIL rnd_data cyc%0d: got %h z%b c%b o%b want %h z%b c%b o%b", c, resp_result, resp_zero, resp_carry, resp_overflow, m_res, m_z, m_c, m_o); end
    end
    rst_n = 1'b1;
    en = 1'b1;
    clear_reqs();
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b1;
    clear_reqs();
    m_ptr = 0; m_rv = 1'b0; m_rid = 0; m_res = '0; m_z = 1'b0; m_c = 1'b0; m_o = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_stall();
    test_idle();
    test_wrap();
    test_fairness();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
